// File: rtl/output_port_allocator_if.sv
// output_port_allocator_if: flit header inputs and grant/status outputs of one output-port allocator
interface output_port_allocator_if #(parameter int CNT_WIDTH = 16);
  logic [1:0] r_adr;
  logic [3:0][3:0] in_ch_hdr_msn;
  logic [3:0] sel;
  logic shift;
  logic busy;
  logic proto_err;
  logic [CNT_WIDTH-1:0] pkt_cnt;
  logic wdog_trip;
  modport master (
    output r_adr, in_ch_hdr_msn,
    input sel, shift, busy, proto_err, pkt_cnt, wdog_trip
  );
  modport slave (
    input r_adr, in_ch_hdr_msn,
    output sel, shift, busy, proto_err, pkt_cnt, wdog_trip
  );
endinterface

// File: rtl/output_port_allocator.sv
// output_port_allocator: round-robin wormhole lock of one output port; ALLOC_WATCHDOG_EN adds an idle-owner stall watchdog
module output_port_allocator #(
  parameter int CNT_WIDTH = 16,
  parameter int WDOG_CYCLES = 64
) (
  input logic clk,
  input logic rst,
  output_port_allocator_if.slave bus
);
  localparam int PORTS = 4;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  if (WDOG_CYCLES < 2 || WDOG_CYCLES > 1023) begin : g_bad_wdog
    $error("WDOG_CYCLES must be in 2..1023");
  end
  logic [0:0] state_q, state_d;
  logic [1:0] owner_q, owner_d, rr_q, rr_d, g, ot;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic perr_q, perr_d;
  logic [PORTS-1:0] req;
`ifdef ALLOC_WATCHDOG_EN
  logic [9:0] stall_q, stall_d;
  logic wdog_q, wdog_d;
`endif
  always_comb begin
    for (int i = 0; i < PORTS; i++)
      req[i] = bus.in_ch_hdr_msn[i][3:2] == 2'b01 && bus.in_ch_hdr_msn[i][1:0] == bus.r_adr;
    g = rr_q;
    for (int k = PORTS - 1; k >= 0; k--)
      if (req[rr_q + 2'(k)]) g = rr_q + 2'(k);
    ot = bus.in_ch_hdr_msn[owner_q][3:2];
    state_d = state_q == IDLE ? (|req ? LOCKED : IDLE) : (ot == 2'b11 ? IDLE : LOCKED);
    owner_d = state_q == IDLE && |req ? g : owner_q;
    rr_d = state_q == IDLE && |req ? g + 2'd1 : rr_q;
    cnt_d = state_q == LOCKED && ot == 2'b11 ? cnt_q + 1'b1 : cnt_q;
    perr_d = state_q == LOCKED && ot == 2'b01;
`ifdef ALLOC_WATCHDOG_EN
    stall_d = state_q == LOCKED && ot == 2'b00 ? stall_q + 10'd1 : '0;
    wdog_d = stall_d == 10'(WDOG_CYCLES);
    state_d = wdog_d ? IDLE : state_d;
    stall_d = wdog_d ? '0 : stall_d;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q <= '0;
      cnt_q <= '0;
      perr_q <= 1'b0;
`ifdef ALLOC_WATCHDOG_EN
      stall_q <= '0;
      wdog_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      perr_q <= perr_d;
`ifdef ALLOC_WATCHDOG_EN
      stall_q <= stall_d;
      wdog_q <= wdog_d;
`endif
    end
  end
  assign bus.sel = rst ? 4'b0000 : state_q == LOCKED ? 4'b0001 << owner_q : |req ? 4'b0001 << g : 4'b0000;
  assign bus.shift = !rst && (state_q == LOCKED ? ot == 2'b01 : |req);
  assign bus.busy = state_q == LOCKED;
  assign bus.proto_err = perr_q;
  assign bus.pkt_cnt = cnt_q;
`ifdef ALLOC_WATCHDOG_EN
  assign bus.wdog_trip = wdog_q;
`else
  assign bus.wdog_trip = 1'b0;
`endif
endmodule

// File: tb/tb_output_port_allocator.sv
// tb_output_port_allocator: directed checks of grant, lock, round-robin, protocol error, reset and watchdog behaviour
module tb_output_port_allocator;
  localparam logic [3:0] I = 4'b0000;
  localparam logic [3:0] B = 4'b1000;
  localparam logic [3:0] T = 4'b1100;
  logic clk, rst;
  int n_chk, n_fail;
  output_port_allocator_if #(.CNT_WIDTH(16)) bus ();
  output_port_allocator #(.CNT_WIDTH(16), .WDOG_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [3:0] hd(input logic [1:0] r);
    return {2'b01, r};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic [3:0] h0, h1, h2, h3);
    @(posedge clk);
    #1;
    rst = r;
    bus.in_ch_hdr_msn = {h3, h2, h1, h0};
    #2;
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.r_adr = 2'd0;
    bus.in_ch_hdr_msn = '0;
    repeat (2) @(posedge clk);
    cyc(1, hd(0), I, I, I);
    chk("rst_sel", 32'(bus.sel), 32'h0);
    chk("rst_shift", 32'(bus.shift), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_cnt", 32'(bus.pkt_cnt), 32'h0);
    chk("rst_perr", 32'(bus.proto_err), 32'h0);
    chk("rst_wdog", 32'(bus.wdog_trip), 32'h0);
    cyc(0, I, I, I, hd(0));
    chk("t5_grant_sel", 32'(bus.sel), 32'h8);
    chk("t5_grant_shift", 32'(bus.shift), 32'h1);
    chk("t5_grant_busy", 32'(bus.busy), 32'h0);
    cyc(0, I, I, I, B);
    chk("t5_body_sel", 32'(bus.sel), 32'h8);
    chk("t5_body_busy", 32'(bus.busy), 32'h1);
    cyc(1, I, I, I, B);
    chk("t5_rst_sel", 32'(bus.sel), 32'h0);
    chk("t5_rst_shift", 32'(bus.shift), 32'h0);
    cyc(0, I, I, I, B);
    chk("t5_after_busy", 32'(bus.busy), 32'h0);
    chk("t5_after_sel", 32'(bus.sel), 32'h0);
    chk("t5_after_cnt", 32'(bus.pkt_cnt), 32'h0);
    cyc(0, I, I, hd(0), I);
    chk("t5_fresh_sel", 32'(bus.sel), 32'h4);
    chk("t5_fresh_shift", 32'(bus.shift), 32'h1);
    cyc(0, I, I, T, I);
    chk("t5_tail_sel", 32'(bus.sel), 32'h4);
    chk("t5_tail_busy", 32'(bus.busy), 32'h1);
    cyc(0, I, I, I, I);
    chk("t5_rel_busy", 32'(bus.busy), 32'h0);
    chk("t5_rel_cnt", 32'(bus.pkt_cnt), 32'h1);
    cyc(0, I, I, hd(1), I);
    chk("t3_sel", 32'(bus.sel), 32'h0);
    chk("t3_shift", 32'(bus.shift), 32'h0);
    cyc(0, I, I, I, I);
    chk("t3_busy", 32'(bus.busy), 32'h0);
    bus.r_adr = 2'd2;
    cyc(0, I, hd(2), I, I);
    chk("t1_head_sel", 32'(bus.sel), 32'h2);
    chk("t1_head_shift", 32'(bus.shift), 32'h1);
    chk("t1_head_busy", 32'(bus.busy), 32'h0);
    cyc(0, I, B, I, I);
    chk("t1_body_sel", 32'(bus.sel), 32'h2);
    chk("t1_body_shift", 32'(bus.shift), 32'h0);
    chk("t1_body_busy", 32'(bus.busy), 32'h1);
    cyc(0, I, T, I, I);
    chk("t1_tail_sel", 32'(bus.sel), 32'h2);
    chk("t1_tail_busy", 32'(bus.busy), 32'h1);
    cyc(0, I, I, I, I);
    chk("t1_done_sel", 32'(bus.sel), 32'h0);
    chk("t1_done_busy", 32'(bus.busy), 32'h0);
    chk("t1_done_cnt", 32'(bus.pkt_cnt), 32'h2);
    bus.r_adr = 2'd0;
    cyc(1, I, I, I, I);
    cyc(0, hd(0), I, I, hd(0));
    chk("t2_rst_cnt", 32'(bus.pkt_cnt), 32'h0);
    chk("t2_first_sel", 32'(bus.sel), 32'h1);
    chk("t2_first_shift", 32'(bus.shift), 32'h1);
    cyc(0, T, I, I, hd(0));
    chk("t2_tail0_sel", 32'(bus.sel), 32'h1);
    chk("t2_tail0_shift", 32'(bus.shift), 32'h0);
    cyc(0, hd(0), I, I, hd(0));
    chk("t2_second_sel", 32'(bus.sel), 32'h8);
    chk("t2_second_busy", 32'(bus.busy), 32'h0);
    chk("t2_second_cnt", 32'(bus.pkt_cnt), 32'h1);
    cyc(0, hd(0), I, I, T);
    chk("t2_tail3_sel", 32'(bus.sel), 32'h8);
    chk("t2_tail3_shift", 32'(bus.shift), 32'h0);
    cyc(0, hd(0), I, I, I);
    chk("t2_third_sel", 32'(bus.sel), 32'h1);
    chk("t2_third_cnt", 32'(bus.pkt_cnt), 32'h2);
    cyc(0, hd(0), I, I, I);
    chk("t4_dup_sel", 32'(bus.sel), 32'h1);
    chk("t4_dup_shift", 32'(bus.shift), 32'h1);
    chk("t4_dup_perr", 32'(bus.proto_err), 32'h0);
    cyc(0, B, I, I, I);
    chk("t4_perr_pulse", 32'(bus.proto_err), 32'h1);
    chk("t4_body_sel", 32'(bus.sel), 32'h1);
    chk("t4_body_shift", 32'(bus.shift), 32'h0);
    cyc(0, T, I, I, I);
    chk("t4_perr_clear", 32'(bus.proto_err), 32'h0);
    cyc(0, I, I, I, I);
    chk("t4_done_busy", 32'(bus.busy), 32'h0);
    chk("t4_done_cnt", 32'(bus.pkt_cnt), 32'h3);
    cyc(0, I, hd(0), I, I);
    chk("t6_grant_sel", 32'(bus.sel), 32'h2);
    for (int n = 0; n < 4; n++) begin
      cyc(0, I, I, I, I);
      chk("t6_stall_sel", 32'(bus.sel), 32'h2);
      chk("t6_stall_busy", 32'(bus.busy), 32'h1);
      chk("t6_stall_wdog", 32'(bus.wdog_trip), 32'h0);
    end
    cyc(0, I, I, I, I);
`ifdef ALLOC_WATCHDOG_EN
    chk("t6_trip_wdog", 32'(bus.wdog_trip), 32'h1);
    chk("t6_trip_busy", 32'(bus.busy), 32'h0);
    chk("t6_trip_sel", 32'(bus.sel), 32'h0);
`else
    chk("t6_hold_wdog", 32'(bus.wdog_trip), 32'h0);
    chk("t6_hold_busy", 32'(bus.busy), 32'h1);
    chk("t6_hold_sel", 32'(bus.sel), 32'h2);
`endif
    cyc(0, I, T, I, I);
    chk("t6_wdog_low", 32'(bus.wdog_trip), 32'h0);
    cyc(0, I, I, I, I);
    chk("t6_end_busy", 32'(bus.busy), 32'h0);
`ifdef ALLOC_WATCHDOG_EN
    chk("t6_end_cnt", 32'(bus.pkt_cnt), 32'h3);
`else
    chk("t6_end_cnt", 32'(bus.pkt_cnt), 32'h4);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
